// File: rtl/display_mode_ctrl.sv
// display_mode_ctrl: drives the VGA output mux select code.
// Mode 0 is the title screen; modes 1..NUM_MODES-1 are camera/processing views.
// Button presses are synchronized and debounced. The title screen is held
// until TITLE_FRAMES frames elapse or a key is pressed. Every mode change is
// applied only on a vsync_pulse, so the mux never switches mid-frame.
// Optional build macro: DISPLAY_MODE_AUTO_CYCLE_EN. When it is defined, RUN
// steps to the next mode after AUTO_FRAMES frames without a button event.
//
// state    | meaning
// ST_TITLE | title screen shown (select 0), counting frames toward timeout
// ST_RUN   | a view mode 1..NUM_MODES-1 is shown
module display_mode_ctrl #(
  parameter int NUM_MODES       = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TITLE_FRAMES    = 300,
  parameter int AUTO_FRAMES     = 600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_home,
  input  logic       vsync_pulse,
  output logic [2:0] select_signal,
  output logic       mode_strobe,
  output logic       req_pending
);

  localparam logic [0:0] ST_TITLE = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [2:0] MODE_LAST = 3'(NUM_MODES - 1);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int FC_MAX = (TITLE_FRAMES > AUTO_FRAMES) ? TITLE_FRAMES : AUTO_FRAMES;
  localparam int FC_W   = $clog2(FC_MAX + 1);

  // Button bit order: 0 = next, 1 = prev, 2 = home
  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      deb_q;
  logic [2:0]      ev_q;
  logic [DB_W-1:0] db_cnt_q [3];

  logic [0:0]      state_q, state_d;
  logic [2:0]      mode_q, mode_d;
  logic [2:0]      tgt_q, tgt_d;
  logic            valid_q, valid_d;
  logic            strobe_q, strobe_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;

  logic       ev_next, ev_prev, ev_home;
  logic       do_step, do_home, apply;
  logic [2:0] base_mode;

  assign btn_raw = {btn_home, btn_prev, btn_next};

  function automatic logic [2:0] next_of(input logic [2:0] m);
    return (m == MODE_LAST) ? 3'd1 : m + 3'd1;
  endfunction

  function automatic logic [2:0] prev_of(input logic [2:0] m);
    return (m == 3'd1) ? MODE_LAST : m - 3'd1;
  endfunction

  // Two-flop synchronizers for the asynchronous pushbuttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level after it has been stable long enough; flag rising edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q <= '0;
      ev_q  <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            deb_q[i]    <= sync2_q[i];
            ev_q[i]     <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            ev_q[i]     <= 1'b0;
            db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
          end
        end else begin
          ev_q[i]     <= 1'b0;
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign ev_next = ev_q[0];
  assign ev_prev = ev_q[1];
  assign ev_home = ev_q[2];
  assign do_home = ev_home;
  assign do_step = !ev_home && (ev_next ^ ev_prev);
  assign apply   = vsync_pulse && valid_q;

  // Events chain off the pending target; on an apply cycle that is also the mode being applied
  assign base_mode = valid_q ? tgt_q : mode_q;

  // Next-state: frame counting, timeouts, frame-aligned apply, then new button events
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    tgt_d    = tgt_q;
    valid_d  = valid_q;
    fcnt_d   = fcnt_q;
    strobe_d = 1'b0;

`ifdef DISPLAY_MODE_AUTO_CYCLE_EN
    if (vsync_pulse && (fcnt_q != '1)) fcnt_d = fcnt_q + FC_W'(1);
    if (!valid_q && (state_q == ST_RUN) && (fcnt_q >= FC_W'(AUTO_FRAMES))) begin
      valid_d = 1'b1;
      tgt_d   = next_of(mode_q);
    end
`else
    if (vsync_pulse && (state_q == ST_TITLE) && (fcnt_q != '1)) fcnt_d = fcnt_q + FC_W'(1);
`endif

    if (!valid_q && (state_q == ST_TITLE) && (fcnt_q >= FC_W'(TITLE_FRAMES))) begin
      valid_d = 1'b1;
      tgt_d   = 3'd1;
    end

    if (apply) begin
      mode_d   = tgt_q;
      strobe_d = (tgt_q != mode_q);
      valid_d  = 1'b0;
      fcnt_d   = '0;
      state_d  = (tgt_q == 3'd0) ? ST_TITLE : ST_RUN;
    end

    if (do_home && (base_mode != 3'd0)) begin
      valid_d = 1'b1;
      tgt_d   = 3'd0;
    end else if (do_step) begin
      valid_d = 1'b1;
      if (base_mode == 3'd0) tgt_d = 3'd1;
      else if (ev_next)      tgt_d = next_of(base_mode);
      else                   tgt_d = prev_of(base_mode);
    end

`ifdef DISPLAY_MODE_AUTO_CYCLE_EN
    if (|ev_q) fcnt_d = '0;
`endif
  end

  // Controller state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_TITLE;
      mode_q   <= 3'd0;
      tgt_q    <= 3'd0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      tgt_q    <= tgt_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign select_signal = mode_q;
  assign mode_strobe   = strobe_q;
  assign req_pending   = valid_q;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Directed bench for display_mode_ctrl with short debounce and frame counts.
module tb_display_mode_ctrl;

  localparam int NUM_MODES = 5;
  localparam int DEB       = 4;
  localparam int TF        = 3;
  localparam int AF        = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic       btn_home = 1'b0;
  logic       vsync_pulse = 1'b0;
  logic [2:0] select_signal;
  logic       mode_strobe;
  logic       req_pending;

  int compared   = 0;
  int mismatched = 0;
  int strobes    = 0;
  int s0;

  display_mode_ctrl #(
    .NUM_MODES      (NUM_MODES),
    .DEBOUNCE_CYCLES(DEB),
    .TITLE_FRAMES   (TF),
    .AUTO_FRAMES    (AF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_next     (btn_next),
    .btn_prev     (btn_prev),
    .btn_home     (btn_home),
    .vsync_pulse  (vsync_pulse),
    .select_signal(select_signal),
    .mode_strobe  (mode_strobe),
    .req_pending  (req_pending)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mode_strobe === 1'b1) strobes++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic vsync();
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
  endtask

  // mask bit 0 = next, 1 = prev, 2 = home
  task automatic press(input logic [2:0] mask);
    btn_next = mask[0];
    btn_prev = mask[1];
    btn_home = mask[2];
    idle(9);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    btn_home = 1'b0;
    idle(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    idle(3);
    check("rst_select", 8'(select_signal), 8'd0);
    check("rst_strobe", 8'(mode_strobe), 8'd0);
    check("rst_pending", 8'(req_pending), 8'd0);
    rst = 1'b0;
    idle(2);

    // Title timeout: target latched after 3rd frame, applied on 4th
    vsync(); idle(4);
    vsync(); idle(4);
    check("title_req_early", 8'(req_pending), 8'd0);
    vsync(); idle(2);
    check("title_req_latched", 8'(req_pending), 8'd1);
    check("title_still_0", 8'(select_signal), 8'd0);
    s0 = strobes;
    vsync();
    check("title_apply_sel", 8'(select_signal), 8'd1);
    check("title_apply_strobe", 8'(mode_strobe), 8'd1);
    check("title_apply_req", 8'(req_pending), 8'd0);
    idle(2);
    check("title_strobe_count", 8'(strobes - s0), 8'd1);
    check("title_strobe_low", 8'(mode_strobe), 8'd0);

    // Three nexts before a frame: 1 -> 4
    press(3'b001); press(3'b001); press(3'b001);
    check("multi_req", 8'(req_pending), 8'd1);
    check("multi_hold_sel", 8'(select_signal), 8'd1);
    vsync();
    check("multi_sel", 8'(select_signal), 8'd4);

    // Mode 4, hold next: pending exactly 7 cycles after press, wraps to 1
    idle(2);
    s0 = strobes;
    btn_next = 1'b1;
    idle(6);
    check("lat_req_c6", 8'(req_pending), 8'd0);
    tick();
    check("lat_req_c7", 8'(req_pending), 8'd1);
    idle(3);
    btn_next = 1'b0;
    idle(10);
    check("wrap_before_vsync", 8'(select_signal), 8'd4);
    vsync();
    check("wrap_sel", 8'(select_signal), 8'd1);
    check("wrap_strobe", 8'(mode_strobe), 8'd1);
    idle(3);
    check("wrap_strobe_count", 8'(strobes - s0), 8'd1);

    // Mode 1, prev twice: 1 -> 4 -> 3
    press(3'b010); press(3'b010);
    check("prev2_req", 8'(req_pending), 8'd1);
    vsync();
    check("prev2_sel", 8'(select_signal), 8'd3);

    // Bouncing next never stable for 4 cycles
    idle(2);
    for (int i = 0; i < 10; i++) begin
      btn_next = ~btn_next;
      idle(2);
    end
    btn_next = 1'b0;
    idle(8);
    check("bounce_req", 8'(req_pending), 8'd0);
    vsync();
    check("bounce_sel", 8'(select_signal), 8'd3);

    // Target equals current mode: valid cleared, no strobe
    press(3'b001); press(3'b010);
    check("same_req", 8'(req_pending), 8'd1);
    s0 = strobes;
    vsync();
    check("same_sel", 8'(select_signal), 8'd3);
    check("same_strobe", 8'(mode_strobe), 8'd0);
    check("same_req_clr", 8'(req_pending), 8'd0);
    idle(2);
    check("same_strobe_count", 8'(strobes - s0), 8'd0);

    // Mode 2: next+prev together ignored; home returns to title
    press(3'b010);
    vsync();
    check("to2_sel", 8'(select_signal), 8'd2);
    idle(2);
    press(3'b011);
    check("both_req", 8'(req_pending), 8'd0);
    vsync();
    check("both_sel", 8'(select_signal), 8'd2);
    press(3'b100);
    check("home_req", 8'(req_pending), 8'd1);
    vsync();
    check("home_sel", 8'(select_signal), 8'd0);
    check("home_strobe", 8'(mode_strobe), 8'd1);

    // Title timeout restarts after home
    idle(3); vsync(); idle(3); vsync(); idle(3);
    check("retitle_req_early", 8'(req_pending), 8'd0);
    vsync(); idle(2);
    check("retitle_req", 8'(req_pending), 8'd1);
    check("retitle_sel_0", 8'(select_signal), 8'd0);
    vsync();
    check("retitle_sel_1", 8'(select_signal), 8'd1);

    // Event coincides with vsync: pending 2 applied, new next chains to 3
    idle(2);
    press(3'b001);
    btn_next = 1'b1;
    idle(6);
    vsync();
    check("coinc_sel", 8'(select_signal), 8'd2);
    check("coinc_req", 8'(req_pending), 8'd1);
    btn_next = 1'b0;
    idle(10);
    vsync();
    check("coinc_next_sel", 8'(select_signal), 8'd3);

    // Async reset while a request is pending
    press(3'b001);
    check("prerst_req", 8'(req_pending), 8'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_sel", 8'(select_signal), 8'd0);
    check("async_rst_req", 8'(req_pending), 8'd0);
    check("async_rst_strobe", 8'(mode_strobe), 8'd0);
    idle(2);
    rst = 1'b0;
    idle(10);
    check("postrst_req", 8'(req_pending), 8'd0);
    check("postrst_sel", 8'(select_signal), 8'd0);

`ifdef DISPLAY_MODE_AUTO_CYCLE_EN
    // Auto-cycle: mode 2 advances to 3 after two counted frames
    vsync(); idle(3); vsync(); idle(3); vsync(); idle(3); vsync();
    check("auto_title_sel", 8'(select_signal), 8'd1);
    press(3'b001);
    vsync();
    check("auto_to2_sel", 8'(select_signal), 8'd2);
    idle(3); vsync(); idle(3);
    check("auto_req_early", 8'(req_pending), 8'd0);
    vsync(); idle(3);
    check("auto_req", 8'(req_pending), 8'd1);
    vsync();
    check("auto_sel", 8'(select_signal), 8'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
